// File: rtl/rv_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// rv_muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - XLEN / ITER widths and the iteration counter width
//   - funct3 operation encodings (op_e)
//   - control FSM state encoding (state_e)
//   - small predicates that classify an op (signedness, divide vs multiply)
// -----------------------------------------------------------------------------
package rv_muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = XLEN;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // rs1 is treated as two's complement.
    function automatic logic op_signed_a(input op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as two's complement.
    function automatic logic op_signed_b(input op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_is_div(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/rv_muldiv_if.sv
// -----------------------------------------------------------------------------
// rv_muldiv_if
// Request/response bundle between the control path and the mul/div unit.
//   start  : request strobe (control path -> unit)
//   op     : RV32M funct3
//   SrcA   : rs1 operand
//   SrcB   : rs2 operand
//   busy   : op in flight (unit -> control path)
//   done   : one-cycle completion pulse
//   Result : registered result, held until the next done
// master = control path side, slave = execution unit side.
// -----------------------------------------------------------------------------
interface rv_muldiv_if;
    import rv_muldiv_pkg::*;

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;

    modport master (
        output start, op, SrcA, SrcB,
        input  busy, done, Result
    );

    modport slave (
        input  start, op, SrcA, SrcB,
        output busy, done, Result
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational conditional two's-complement negate. With negate_i tied to the
// operand's sign bit it yields the magnitude (abs); with negate_i set to the
// result sign it restores a signed result from an unsigned magnitude.
//   value_i  : input value (WIDTH bits)
//   negate_i : 1 -> output is -value_i, 0 -> pass-through
//   value_o  : result (WIDTH bits)
// -----------------------------------------------------------------------------
module muldiv_sign_fix #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] value_o
);

    assign value_o = negate_i ? -value_i : value_i;

endmodule

// File: rtl/rv_muldiv.sv
// -----------------------------------------------------------------------------
// rv_muldiv
// Iterative RV32M multiply/divide unit with a fixed 33-cycle latency.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; discards any in-flight op
//   bus   : rv_muldiv_if.slave (start/op/SrcA/SrcB in, busy/done/Result out)
//
// Accept edge: operands are latched as magnitudes plus sign flags. RUN then
// performs ITER steps on a shared 64-bit accumulator:
//   multiply: unsigned shift-add, acc = {partial product, multiplier}
//   divide  : restoring shift-subtract, acc = {remainder, dividend/quotient}
// FIX applies the sign correction and the divide special cases, registers
// Result and raises done for one cycle.
// -----------------------------------------------------------------------------
module rv_muldiv
    import rv_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    rv_muldiv_if.slave  bus
);

    // ------------------------------------------------------------------ state
    state_e            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic [XLEN-1:0]   opb_q,    opb_d;    // multiplicand / divisor magnitude
    logic [XLEN-1:0]   a_q,      a_d;      // raw rs1, kept for special cases
    logic [XLEN-1:0]   b_q,      b_d;      // raw rs2, kept for special cases
    op_e               op_q,     op_d;
    logic              sa_q,     sa_d;
    logic              sb_q,     sb_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [XLEN-1:0]   result_q, result_d;

    // -------------------------------------------------------- operand capture
    op_e             op_in;
    logic            sa_in, sb_in;
    logic [XLEN-1:0] a_mag, b_mag;

    assign op_in = op_e'(bus.op);
    assign sa_in = op_signed_a(op_in) & bus.SrcA[XLEN-1];
    assign sb_in = op_signed_b(op_in) & bus.SrcB[XLEN-1];

    muldiv_sign_fix #(.WIDTH(XLEN)) u_abs_a (
        .value_i  (bus.SrcA),
        .negate_i (sa_in),
        .value_o  (a_mag)
    );

    muldiv_sign_fix #(.WIDTH(XLEN)) u_abs_b (
        .value_i  (bus.SrcB),
        .negate_i (sb_in),
        .value_o  (b_mag)
    );

    // ---------------------------------------------------------- step datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    // The carry out of the add becomes the new MSB as the accumulator shifts right.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Partial remainder is one bit wider than the divisor after the shift;
    // when it fits, the difference is below 2^XLEN, so XLEN bits suffice.
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift[XLEN-1:0] - opb_q;
    assign div_next  = div_ge ? {div_diff,             acc_q[XLEN-2:0], 1'b1}
                              : {div_shift[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0};

    // ------------------------------------------------------- result fix-up
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic              fix_neg;
    logic              div_by_zero, div_ovf;
    logic [XLEN-1:0]   fix_result;

    assign div_by_zero = (b_q == '0);
    assign div_ovf     = op_signed_b(op_q) && op_is_div(op_q)
                         && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        fix_in  = acc_q;
        fix_neg = sa_q ^ sb_q;
        if (op_is_rem(op_q)) begin
            fix_in  = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
            fix_neg = sa_q;                    // remainder follows dividend sign
        end else if (op_is_div(op_q)) begin
            fix_in  = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
        end
    end

    muldiv_sign_fix #(.WIDTH(2*XLEN)) u_fix (
        .value_i  (fix_in),
        .negate_i (fix_neg),
        .value_o  (fix_out)
    );

    always_comb begin
        fix_result = fix_out[XLEN-1:0];
        unique case (op_q)
            OP_MUL:                     fix_result = fix_out[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = fix_out[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (div_by_zero)  fix_result = '1;
                else if (div_ovf) fix_result = {1'b1, {(XLEN-1){1'b0}}};
                else              fix_result = fix_out[XLEN-1:0];
            end
            OP_REM, OP_REMU: begin
                if (div_by_zero)  fix_result = a_q;
                else if (div_ovf) fix_result = '0;
                else              fix_result = fix_out[XLEN-1:0];
            end
            default:                    fix_result = fix_out[XLEN-1:0];
        endcase
    end

    // -------------------------------------------------------- next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    op_d    = op_in;
                    a_d     = bus.SrcA;
                    b_d     = bus.SrcB;
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    opb_d   = b_mag;
                    cnt_d   = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) state_d = FIX;
            end
            FIX: begin
                result_d = fix_result;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // -------------------------------------------------------- registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Result = result_q;

endmodule

// File: doc/rv_muldiv.md
Name: rv_muldiv

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits beside the single-cycle ALU. The control path issues an M-extension op with a start pulse and stalls the PC while busy is high.
- Takes the same SrcA/SrcB operands the ALU sees and returns Result with a one-cycle done pulse.
- Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with fixed latency.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- ITER, 32, iteration count, equal to XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE or DONE
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  32  rs1 operand; captured on the accepting edge
- SrcB  input  32  rs2 operand; captured on the accepting edge
- busy  output  1  high while an op is in flight
- done  output  1  one-cycle pulse; Result is valid in this cycle
- Result  output  32  registered result; held until the next done

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, Result=0, all internal registers 0. Takes effect immediately, including mid-operation; the in-flight op is discarded.
- States and transitions:
  - IDLE: start=1 -> RUN.
  - RUN: runs ITER iterations, then -> FIX.
  - FIX: -> DONE.
  - DONE: start=1 -> RUN, else -> IDLE.
- Accept edge E0 (start=1 in IDLE or DONE):
  - Latch op, SrcA, SrcB.
  - Latch sign flags: sA = SrcA[31] for MULH/MULHSU/DIV/REM; sB = SrcB[31] for MULH/DIV/REM; both 0 otherwise.
  - Convert operands to magnitudes; zero the counter; busy=1 from E0.
- Edges E1..E32, one step each:
  - Multiply: unsigned shift-add on the 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
- Edge E33 (FIX -> DONE):
  - Apply sign fix-up and special-case overrides.
  - Register Result; done=1 and busy=0 for the cycle following E33.
  - Latency is fixed at 33 cycles from the accept edge for every op, including special cases.
- Multiply selection:
  - Product sign = sA^sB; negate the 64-bit magnitude when set.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide signs: quotient sign = sA^sB; remainder sign = sA.
- Divide by zero (SrcB=0):
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU remainder = SrcA unchanged.
- Signed overflow (DIV/REM with SrcA=0x80000000 and SrcB=0xFFFFFFFF):
  - Quotient = 0x80000000; remainder = 0.
- start while in RUN or FIX is ignored; the in-flight op completes unaffected.
- start during DONE is accepted back-to-back: done is high in that cycle and busy returns to 1 on the following cycle.
- The unit raises no exceptions.

Decomposition:
- Shared package rv_muldiv_pkg holds:
  - XLEN and ITER constants.
  - funct3 op encodings: OP_MUL..OP_REMU.
  - State enum: IDLE, RUN, FIX, DONE.
  - Helper predicate for signed ops.
- One sub-module, muldiv_sign_fix: combinational two's-complement negate/abs on 64 bits. Instantiated for operand magnitudes and the result fix-up.
- The datapath and FSM stay in rv_muldiv.

Test Plan:
- MUL, SrcA=7, SrcB=0xFFFFFFFD -> done exactly 33 cycles after the accept edge; Result=0xFFFFFFEB; busy high for cycles 1..33.
- Upper-word multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
  - All complete with 33-cycle latency.
- Handshake:
  - start with new operands at cycle 5 of a running MUL -> ignored; the original result is returned.
  - start in the DONE cycle -> accepted; the second done arrives 33 cycles later.
- reset asserted mid-RUN at cycle 10 -> busy=0, done=0, Result=0 immediately; no done pulse follows; the next start completes normally.
